// File: rtl/rmw_pkg.sv
// Shared types and mask constants for the masked read-modify-write engine
// and the register-file flag update path.
package rmw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } rmw_state_e;

  // Wide enough for any supported word size; users slice to their width.
  localparam int RMW_MAX_WIDTH = 64;
  localparam logic [RMW_MAX_WIDTH-1:0] MASK_NONE = '0;
  localparam logic [RMW_MAX_WIDTH-1:0] MASK_ALL  = '1;

endpackage

// File: rtl/mask_merge.sv
// Combinational bit merge: mask=1 takes new_dat, mask=0 keeps old_dat.
// Zero latency, no flow control.
module mask_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] old_dat,
  input  logic [WIDTH-1:0] new_dat,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] merged_dat
);

  assign merged_dat = (old_dat & ~mask) | (new_dat & mask);

endmodule

// File: rtl/masked_rmw.sv
// Masked read-modify-write of one memory word over a req/ack bus; 3 cycles
// with zero-wait acks (fewer for empty/full masks), strobes held until mem_ack.
module masked_rmw
  import rmw_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] mask_in,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] old_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ack
);

  localparam logic [DATA_WIDTH-1:0] ZERO_MASK = MASK_NONE[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] FULL_MASK = MASK_ALL[DATA_WIDTH-1:0];

  rmw_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] old_q, old_d;
  logic [DATA_WIDTH-1:0] merged_q, merged_d;
  logic [DATA_WIDTH-1:0] merge_out;

  mask_merge #(.WIDTH(DATA_WIDTH)) u_merge (
    .old_dat    (mem_data_in),
    .new_dat    (data_q),
    .mask       (mask_q),
    .merged_dat (merge_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      old_q    <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      old_q    <= old_d;
      merged_q <= merged_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mask_in == ZERO_MASK)      state_d = DONE;
          else if (mask_in == FULL_MASK) state_d = WRITE;
          else                           state_d = READ;
        end
      end
      READ:    if (mem_ack) state_d = WRITE;
      WRITE:   if (mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Seeding merged with data_in makes the full-mask path write data directly.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    old_d    = old_q;
    merged_d = merged_q;
    if (state_q == IDLE && start) begin
      addr_d   = addr_in;
      data_d   = data_in;
      mask_d   = mask_in;
      old_d    = '0;
      merged_d = data_in;
    end else if (state_q == READ && mem_ack) begin
      old_d    = mem_data_in;
      merged_d = merge_out;
    end
  end

  always_comb begin
    ready  = (state_q == IDLE);
    done   = (state_q == DONE);
    mem_rd = (state_q == READ);
    mem_wr = (state_q == WRITE);
  end

  assign old_data     = old_q;
  assign mem_addr     = addr_q;
  assign mem_data_out = merged_q;

endmodule

// File: tb/tb_masked_rmw.sv
// Directed bench for masked_rmw: a behavioural word memory with programmable
// ack wait states answers the bus; outputs are sampled on the falling edge.
module tb_masked_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [15:0] addr_in = '0;
  logic [31:0] data_in = '0;
  logic [31:0] mask_in = '0;
  logic        done;
  logic [31:0] old_data;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in = '0;
  logic        mem_ack = 1'b0;

  masked_rmw #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ready        (ready),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .mask_in      (mask_in),
    .done         (done),
    .old_data     (old_data),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model state
  logic [31:0] mem [256];
  int          rd_wait = 0, wr_wait = 0, wait_cnt = 0;
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, other_addr_cnt = 0;
  logic [15:0] exp_addr = '0;
  logic [31:0] wr_data = '0;
  logic        held = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [31:0] prev_dout = '0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;

  always @(negedge clk) begin
    check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
    if (done) done_cnt++;
    if (held && (mem_rd || mem_wr)) begin
      check("hold_rd", 32'(mem_rd), 32'(prev_rd));
      check("hold_wr", 32'(mem_wr), 32'(prev_wr));
      check("hold_addr", 32'(mem_addr), 32'(prev_addr));
      if (mem_wr) check("hold_wdata", mem_data_out, prev_dout);
    end
    mem_ack = 1'b0;
    if (mem_rd || mem_wr) begin
      if (mem_addr != exp_addr) other_addr_cnt++;
      if (wait_cnt == (mem_rd ? rd_wait : wr_wait)) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        held     = 1'b0;
        if (mem_rd) begin
          mem_data_in = mem[mem_addr[7:0]];
          rd_cnt++;
        end else begin
          mem[mem_addr[7:0]] = mem_data_out;
          wr_data = mem_data_out;
          wr_cnt++;
        end
      end else begin
        wait_cnt++;
        held      = 1'b1;
        prev_rd   = mem_rd;
        prev_wr   = mem_wr;
        prev_addr = mem_addr;
        prev_dout = mem_data_out;
      end
    end else begin
      wait_cnt = 0;
      held     = 1'b0;
    end
  end

  // Issues one transaction; cyc counts falling edges after the accept edge
  // up to and including the one where done is seen.
  task automatic run_txn(input logic [15:0] a, input logic [31:0] d, input logic [31:0] m,
                         input int rw, input int ww, input bit poke, output int cyc);
    rd_wait = rw; wr_wait = ww; exp_addr = a;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; other_addr_cnt = 0; wr_data = '0;
    @(negedge clk);
    check("ready_before", 32'(ready), 32'd1);
    addr_in = a; data_in = d; mask_in = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    if (poke) begin
      addr_in = 16'h0020; data_in = 32'h0; mask_in = 32'h0000FFFF; start = 1'b1;
    end
    while (!done && cyc < 60) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("ready_in_done", 32'(ready), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after_done", 32'(ready), 32'd1);
  endtask

  int cyc;
  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'h12345678;
    mem[32] = 32'hCAFEF00D;
    mem[48] = 32'h11111111;
    mem[64] = 32'h55555555;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_old_data", old_data, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_dout", mem_data_out, 32'd0);
    rst = 1'b0;

    // Partial mask, zero-wait memory
    run_txn(16'h0010, 32'hAAAAAAAA, 32'h0000FFFF, 0, 0, 1'b0, cyc);
    check("p_latency", 32'(cyc), 32'd3);
    check("p_rd_cnt", 32'(rd_cnt), 32'd1);
    check("p_wr_cnt", 32'(wr_cnt), 32'd1);
    check("p_wdata", wr_data, 32'h1234AAAA);
    check("p_mem", mem[16], 32'h1234AAAA);
    check("p_old", old_data, 32'h12345678);
    check("p_addr", 32'(other_addr_cnt), 32'd0);

    // Wait states: read acked after 2 waits, write after 3
    mem[16] = 32'h12345678;
    run_txn(16'h0010, 32'hAAAAAAAA, 32'h0000FFFF, 2, 3, 1'b0, cyc);
    check("w_latency", 32'(cyc), 32'd8);
    check("w_rd_cnt", 32'(rd_cnt), 32'd1);
    check("w_wr_cnt", 32'(wr_cnt), 32'd1);
    check("w_wdata", wr_data, 32'h1234AAAA);
    check("w_old", old_data, 32'h12345678);

    // Zero mask: no bus traffic, old_data cleared
    run_txn(16'h0040, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1'b0, cyc);
    check("z_latency", 32'(cyc), 32'd1);
    check("z_rd_cnt", 32'(rd_cnt), 32'd0);
    check("z_wr_cnt", 32'(wr_cnt), 32'd0);
    check("z_mem", mem[64], 32'h55555555);
    check("z_old", old_data, 32'd0);

    // Full mask: read skipped
    run_txn(16'h0030, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0, 1'b0, cyc);
    check("f_latency", 32'(cyc), 32'd2);
    check("f_rd_cnt", 32'(rd_cnt), 32'd0);
    check("f_wr_cnt", 32'(wr_cnt), 32'd1);
    check("f_wdata", wr_data, 32'hDEADBEEF);
    check("f_mem", mem[48], 32'hDEADBEEF);
    check("f_old", old_data, 32'd0);

    // Start pulse to 0x0020 during READ must be dropped
    mem[16] = 32'h12345678;
    run_txn(16'h0010, 32'hAAAAAAAA, 32'h0000FFFF, 2, 0, 1'b1, cyc);
    check("b_latency", 32'(cyc), 32'd5);
    check("b_other_addr", 32'(other_addr_cnt), 32'd0);
    check("b_done_cnt", 32'(done_cnt), 32'd1);
    check("b_mem20", mem[32], 32'hCAFEF00D);
    check("b_mem10", mem[16], 32'h1234AAAA);
    repeat (3) @(negedge clk);
    check("b_no_second", 32'(done_cnt), 32'd1);
    check("b_idle", 32'(ready), 32'd1);

    // Reset while WRITE is waiting for an ack that never comes
    mem[16] = 32'h12345678;
    rd_wait = 0; wr_wait = 99; exp_addr = 16'h0010; wr_cnt = 0; done_cnt = 0;
    @(negedge clk);
    addr_in = 16'h0010; data_in = 32'hAAAAAAAA; mask_in = 32'h0000FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!mem_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("r_reach_write", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("r_mem_wr", 32'(mem_wr), 32'd0);
    check("r_ready", 32'(ready), 32'd1);
    check("r_done", 32'(done), 32'd0);
    check("r_mem", mem[16], 32'h12345678);
    check("r_wr_cnt", 32'(wr_cnt), 32'd0);
    run_txn(16'h0010, 32'hAAAAAAAA, 32'h0000FFFF, 0, 0, 1'b0, cyc);
    check("r2_latency", 32'(cyc), 32'd3);
    check("r2_mem", mem[16], 32'h1234AAAA);
    check("r2_old", old_data, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/masked_rmw.md
Name: masked_rmw

Overview:
- Write-side counterpart of the CPU's mask/filter path. The filter extracts selected bits of a word; masked_rmw writes selected bits into a memory word and leaves the others unchanged.
- It does this as a read-modify-write over a simple req/ack memory bus: new = (old & ~mask) | (data & mask).
- Sits between the execute stage (bit-field stores, flag-register updates) and the memory/register-file bus arbiter. One transaction is in flight at a time.

Parameters:
- DATA_WIDTH, 32, word width of data, mask and memory data.
- ADDR_WIDTH, 16, memory word-address width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; accepted only when ready=1.
- ready  output  1  high in IDLE only.
- addr_in  input  ADDR_WIDTH  target word address.
- data_in  input  DATA_WIDTH  value to insert.
- mask_in  input  DATA_WIDTH  1 = bit is replaced by data_in, 0 = bit is preserved.
- done  output  1  one-cycle pulse when the transaction completes.
- old_data  output  DATA_WIDTH  word read before modification; held until the next accept.
- mem_addr  output  ADDR_WIDTH  bus address.
- mem_rd  output  1  read request; held until mem_ack.
- mem_wr  output  1  write request; held until mem_ack.
- mem_data_out  output  DATA_WIDTH  write data.
- mem_data_in  input  DATA_WIDTH  read data, valid when mem_ack=1 in READ.
- mem_ack  input  1  bus acknowledge; completes the current request in the same cycle.

Behaviour:
- Reset (sync, rst=1 at the edge):
  - state goes to IDLE; ready=1; done=0; mem_rd=0; mem_wr=0.
  - old_data, mem_addr and mem_data_out are all 0.
  - Reset mid-transaction aborts it at that edge with no further bus strobes. A write already acked is not undone.
- Strobe timing: mem_rd, mem_wr, ready and done decode from the registered state only. No combinational path from any input to any output.
- IDLE:
  - On start=1, latch addr_in, data_in and mask_in.
  - mask_in == 0 → DONE. No bus traffic; old_data = 0.
  - mask_in == all ones → WRITE. Read is skipped; old_data = 0.
  - Otherwise → READ.
  - start while not in IDLE is ignored and not queued.
- READ:
  - mem_rd=1 and mem_addr=latched address.
  - On mem_ack: old_data ← mem_data_in; merged ← (mem_data_in & ~mask) | (data & mask); go to WRITE.
  - Without ack, stay in READ with a stable request.
- WRITE:
  - mem_wr=1, mem_addr=latched address, mem_data_out=merged.
  - On the full-mask path, merged = data.
  - On mem_ack → DONE; without ack, hold.
- DONE: done=1 for exactly one cycle, then IDLE. ready=1 is next seen one cycle after done.
- mem_rd and mem_wr are never high together.
- mem_ack is ignored in IDLE and DONE.
- Latency with zero-wait ack (ack in the first cycle of each request), taking the accept edge as cycle 0:
  - partial mask: READ in cycle 1, WRITE in cycle 2, done in cycle 3.
  - full mask: done in cycle 2.
  - zero mask: done in cycle 1.
  - Each extra wait cycle adds 1.
- There are no width conversions; all operands are DATA_WIDTH.

Decomposition:
- rmw_pkg holds:
  - typedef enum logic [1:0] rmw_state_e {IDLE, READ, WRITE, DONE};
  - the zero-mask and full-mask constants, expressed as '0 and '1.
- Sub-module mask_merge is purely combinational: inputs old, new, mask; output (old & ~mask) | (new & mask). It is reused by the register-file flag update path.
- The FSM and latches stay in masked_rmw.

Test Plan:
- Partial mask, zero-wait memory:
  - stimulus: mem[0x0010]=0x12345678, start with addr=0x0010, data=0xAAAAAAAA, mask=0x0000FFFF.
  - required: one read; write of 0x1234AAAA; old_data=0x12345678; done 3 cycles after accept.
- Wait states:
  - stimulus: same as the partial-mask case, with mem_ack delayed 2 cycles on the read and 3 on the write.
  - required: mem_rd and mem_wr held stable throughout; write data 0x1234AAAA; done 8 cycles after accept.
- Full mask:
  - stimulus: mask=0xFFFFFFFF, data=0xDEADBEEF.
  - required: no mem_rd ever asserted; single write of 0xDEADBEEF; old_data=0; done at cycle 2.
- Zero mask:
  - stimulus: mask=0x00000000.
  - required: mem_rd=mem_wr=0 throughout; done at cycle 1; memory unchanged.
- Start while busy:
  - stimulus: pulse start with addr=0x0020 during READ of a transaction to 0x0010.
  - required: ignored; only address 0x0010 is accessed; one done pulse.
- Reset mid-operation:
  - stimulus: assert rst for 1 cycle while in WRITE, with ack withheld.
  - required: at the next edge mem_wr=0, ready=1, done=0; memory unchanged; a new transaction then completes normally.
